inst_encoder_loader: RTL and testbench
======================================

# inst_encoder_loader

Sequential RV32I instruction encoder and instruction-memory loader. Accepts field-level instruction requests over a valid/ready handshake, assembles each into a 32-bit word, and writes it to consecutive instruction-memory addresses. It covers exactly the formats the core's control decoder recognises: R-ALU, I-ALU, LOAD, STORE, BRANCH, JAL, and the all-zero word. It sits between the test/boot host and the instruction memory, ahead of the fetch path.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after `start`
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load session; sampled only in IDLE
- req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both high on an edge
- req_kind  in  3  0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 ZERO, 7 reserved
- req_funct3 / req_funct7  in  3 / 7  function fields
- req_rd / req_rs1 / req_rs2  in  5 each  register indices
- req_imm  in  21  signed immediate (byte offset for BRANCH/JAL)
- req_last  in  1  final instruction of the session
- imem_we / imem_addr / imem_wdata  out  1 / ADDR_W / 32  write port
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at session end
- inst_count  out  ADDR_W+1  words written this session
- err_code  out  2  0 none, 1 bad kind, 2 overflow, 3 immediate range; first error is sticky

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE: req_ready=0. When start=1: clear ptr, inst_count, err_code; go to ACCEPT.
- ACCEPT: req_ready=1. On handshake: register the encoded word and req_last, go to WRITE.
- WRITE: imem_we=1, imem_addr=(BASE_ADDR+ptr) mod 2^ADDR_W. ptr++ and inst_count++.
  - Go to DONE when last=1, or when inst_count reaches 2^ADDR_W (this sets err_code 2 if last=0).
  - Otherwise go back to ACCEPT.
- DONE: done=1 for one cycle, then IDLE.
- Encodings, opcodes as in the core decoder:
  - R: funct7|rs2|rs1|f3|rd|0110011
  - I: imm[11:0]|rs1|f3|rd|0010011. For shifts the caller places funct7 in imm[11:5].
  - LOAD: same layout as I with opcode 0000011
  - STORE: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011. imm[0] is ignored.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111
  - ZERO: 32'h0
- Kind 7: writes 32'h0 and sets err_code 1 if no earlier error.
- start outside IDLE is ignored. Errors never stop a session except overflow.

## Timing
- Reset values: state IDLE, req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, inst_count 0, err_code 0. Reset applies immediately, mid-write included.
- All outputs are registered or decoded from state; no combinational path from req_* to outputs.
- Latency: handshake on edge N gives imem_we high for the whole cycle following N.
- Throughput: one instruction per 2 cycles. done pulses 1 cycle after the last write; busy falls in the cycle after DONE.

## Configuration
- INST_ENC_IMM_CHECK_EN defined: the block range-checks req_imm and sets err_code 3 (if no earlier error) on violation. The word is still written with truncated fields.
  - I/LOAD/STORE must be in [-2048, 2047].
  - BRANCH must be in [-4096, 4094] and even.
  - JAL must be even.
- Undefined: silent truncation; err_code 3 is never produced.

## Structure
- Shared package holds the opcode constants, the req_kind enumeration, the err_code values, and the FSM state type. Opcode constants match the control decoder's.
- One sub-module, `inst_field_pack`: combinational request fields -> 32-bit word plus range-violation flag. The FSM, pointer, and counters stay in the top.

## Test plan
- R add: kind 0, f3 0, f7 0, rd 3, rs1 1, rs2 2 -> imem_wdata 0x002081B3 at addr 0; imem_we high exactly the cycle after handshake.
- I addi: kind 1, rd 1, rs1 0, imm -1 -> 0xFFF00093. STORE sw: kind 3, f3 2, rs1 1, rs2 2, imm 8 -> 0x0020A423.
- BRANCH beq: kind 4, rs1 1, rs2 2, imm -4 -> 0xFE208EE3. JAL: kind 5, rd 1, imm 8, last 1 -> 0x008000EF, done pulse next cycle, inst_count 1.
- ADDR_W=2, BASE_ADDR=1, 4 requests with last=0 -> addrs 1,2,3,0; err_code 2; done; further valid not accepted.
- Kind 7 followed by imm 4096 on kind 1 -> words 0x0 then truncated word; err_code stays 1. With macro and a clean session, imm 4096 on kind 1 -> err_code 3.
- rst_n low during WRITE -> imem_we 0 in the same cycle, all outputs at reset values. start asserted while busy -> no effect on ptr or count.

Source files
------------

// File: rtl/inst_encoder_loader_pkg.sv
// +--------------------------------------------------------------------+
// | inst_encoder_loader_pkg                                            |
// | Opcodes, request kinds, error codes and FSM state type shared by   |
// | the instruction encoder/loader.                                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package inst_encoder_loader_pkg;

  // Opcodes as recognised by the core's control decoder
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    KIND_R      = 3'd0,
    KIND_I      = 3'd1,
    KIND_LOAD   = 3'd2,
    KIND_STORE  = 3'd3,
    KIND_BRANCH = 3'd4,
    KIND_JAL    = 3'd5,
    KIND_ZERO   = 3'd6,
    KIND_RSVD   = 3'd7
  } req_kind_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_KIND      = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_IMM_RANGE = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/inst_encoder_loader_if.sv
// +--------------------------------------------------------------------+
// | inst_encoder_loader_if                                             |
// | Request handshake and instruction-memory write port bundle.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface inst_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [2:0]        req_funct3;
  logic [6:0]        req_funct7;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [20:0]       req_imm;
  logic              req_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_kind, req_funct3, req_funct7, req_rd, req_rs1,
           req_rs2, req_imm, req_last,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_funct3, req_funct7, req_rd, req_rs1,
           req_rs2, req_imm, req_last,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/inst_field_pack.sv
// +--------------------------------------------------------------------+
// | inst_field_pack                                                    |
// | Combinational RV32I field packer with optional immediate range     |
// | check (enabled by INST_ENC_IMM_CHECK_EN).                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module inst_field_pack
  import inst_encoder_loader_pkg::*;
(
  input  req_kind_e   kind,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        imm_bad
);

  always_comb begin
    word = 32'h0;
    case (kind)
      KIND_R:      word = {funct7, rs2, rs1, funct3, rd, OPC_R};
      KIND_I:      word = {imm[11:0], rs1, funct3, rd, OPC_I};
      KIND_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      KIND_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      KIND_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      default:     word = 32'h0;
    endcase
  end

`ifdef INST_ENC_IMM_CHECK_EN
  // A value fits n signed bits when every bit above n-1 equals the sign bit
  logic w_fits12;
  logic w_fits13;
  assign w_fits12 = (imm[20:11] == {10{imm[11]}});
  assign w_fits13 = (imm[20:12] == {9{imm[12]}});

  always_comb begin
    imm_bad = 1'b0;
    case (kind)
      KIND_I, KIND_LOAD, KIND_STORE: imm_bad = !w_fits12;
      KIND_BRANCH:                   imm_bad = !w_fits13 || imm[0];
      KIND_JAL:                      imm_bad = imm[0];
      default:                       imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/inst_encoder_loader.sv
// +--------------------------------------------------------------------+
// | inst_encoder_loader                                                |
// | Encodes field-level requests and writes them to consecutive imem   |
// | words. Optional immediate check via INST_ENC_IMM_CHECK_EN.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  inst_encoder_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      inst_count,
  output logic [1:0]           err_code
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  err_code_e         r_err;
  logic              r_ready;
  logic              r_we;
  logic              r_done;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic [31:0]       w_word;
  logic              w_imm_bad;
  logic [ADDR_W:0]   w_count_next;
  logic              w_full;

  inst_field_pack u_pack (
    .kind    (req_kind_e'(bus.req_kind)),
    .funct3  (bus.req_funct3),
    .funct7  (bus.req_funct7),
    .rd      (bus.req_rd),
    .rs1     (bus.req_rs1),
    .rs2     (bus.req_rs2),
    .imm     (bus.req_imm),
    .word    (w_word),
    .imm_bad (w_imm_bad)
  );

  assign w_count_next = r_count + (ADDR_W+1)'(1);
  // Memory is full once the incremented count carries into the top bit
  assign w_full       = w_count_next[ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= ERR_NONE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= ERR_NONE;
            r_ready <= 1'b1;
            r_state <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (bus.req_valid && r_ready) begin
            r_ready <= 1'b0;
            r_we    <= 1'b1;
            r_addr  <= r_ptr + BASE;
            r_wdata <= w_word;
            r_last  <= bus.req_last;
            if (r_err == ERR_NONE) begin
              if (req_kind_e'(bus.req_kind) == KIND_RSVD) r_err <= ERR_KIND;
              else if (w_imm_bad)                         r_err <= ERR_IMM_RANGE;
            end
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_count <= w_count_next;
          if (r_last || w_full) begin
            if (!r_last && r_err == ERR_NONE) r_err <= ERR_OVERFLOW;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_ACCEPT;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;
  assign inst_count     = r_count;
  assign err_code       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
// +--------------------------------------------------------------------+
// | tb_inst_encoder_loader                                             |
// | Randomized self-checking bench against a behavioural model.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_inst_encoder_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, busy, done;
  logic [10:0] inst_count;
  logic [1:0]  err_code;
  inst_encoder_loader_if #(.ADDR_W(10)) bus ();
  inst_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .inst_count(inst_count), .err_code(err_code)
  );

  logic        start_s, busy_s, done_s;
  logic [2:0]  inst_count_s;
  logic [1:0]  err_code_s;
  inst_encoder_loader_if #(.ADDR_W(2)) sbus ();
  inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .bus(sbus),
    .busy(busy_s), .done(done_s), .inst_count(inst_count_s), .err_code(err_code_s)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int m_ptr, m_count, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoding built from bit positions with plain arithmetic
  function automatic logic [31:0] ref_word(int k, int f3, int f7, int rd, int rs1, int rs2, int imm);
    int unsigned u;
    int unsigned b;
    u = imm;
    b = (f3 << 12) | (rs1 << 15);
    case (k)
      0: return 32'h33 | (rd << 7) | b | (rs2 << 20) | (f7 << 25);
      1: return 32'h13 | (rd << 7) | b | ((u & 'hFFF) << 20);
      2: return 32'h03 | (rd << 7) | b | ((u & 'hFFF) << 20);
      3: return 32'h23 | ((u & 'h1F) << 7) | b | (rs2 << 20) | (((u >> 5) & 'h7F) << 25);
      4: return 32'h63 | (((u >> 11) & 1) << 7) | (((u >> 1) & 'hF) << 8) | b | (rs2 << 20)
                | (((u >> 5) & 'h3F) << 25) | (((u >> 12) & 1) << 31);
      5: return 32'h6F | (rd << 7) | (u & 'hFF000) | (((u >> 11) & 1) << 20)
                | (((u >> 1) & 'h3FF) << 21) | (((u >> 20) & 1) << 31);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_imm_bad(int k, int imm);
`ifdef INST_ENC_IMM_CHECK_EN
    case (k)
      1, 2, 3: return (imm < -2048) || (imm > 2047);
      4:       return (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
      5:       return (imm & 1) != 0;
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  task automatic start_session();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    m_ptr = 0; m_count = 0; m_err = 0;
    check("busy_start", {31'b0, busy}, 1);
    check("ready_start", {31'b0, bus.req_ready}, 1);
    check("count_clear", {21'b0, inst_count}, 0);
    check("err_clear", {30'b0, err_code}, 0);
  endtask

  task automatic do_req(input int k, input int f3, input int f7, input int rd, input int rs1,
                        input int rs2, input int imm, input bit last, input bit poke_start);
    int n;
    logic [31:0] exp_word;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_kind = 3'(k); bus.req_funct3 = 3'(f3);
    bus.req_funct7 = 7'(f7); bus.req_rd = 5'(rd); bus.req_rs1 = 5'(rs1);
    bus.req_rs2 = 5'(rs2); bus.req_imm = 21'(imm); bus.req_last = last;
    start = poke_start;
    while (bus.req_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    if (bus.req_ready !== 1'b1) begin
      check("handshake_timeout", 0, 1);
      bus.req_valid = 1'b0; start = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; start = 1'b0;
    exp_word = ref_word(k, f3, f7, rd, rs1, rs2, imm);
    if (m_err == 0) m_err = (k == 7) ? 1 : (ref_imm_bad(k, imm) ? 3 : 0);
    check("we", {31'b0, bus.imem_we}, 1);
    check("addr", {22'b0, bus.imem_addr}, 32'(m_ptr % 1024));
    check("wdata", bus.imem_wdata, exp_word);
    check("ready_in_write", {31'b0, bus.req_ready}, 0);
    m_ptr++; m_count++;
    @(posedge clk); #1;
    check("we_drop", {31'b0, bus.imem_we}, 0);
    check("count", {21'b0, inst_count}, 32'(m_count));
    check("err", {30'b0, err_code}, 32'(m_err));
    if (last) begin
      check("done", {31'b0, done}, 1);
      @(posedge clk); #1;
      check("done_drop", {31'b0, done}, 0);
      check("busy_end", {31'b0, busy}, 0);
    end else begin
      check("ready_back", {31'b0, bus.req_ready}, 1);
    end
  endtask

  task automatic rand_req(input bit last);
    logic [20:0] r;
    int imm;
    r = 21'($urandom);
    case ($urandom_range(0, 2))
      0:       imm = int'($urandom_range(0, 4095)) - 2048;
      1:       imm = int'($signed(r));
      default: imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
    endcase
    do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           imm, last, bit'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    int n;
    logic [31:0] w;
    start = 1'b0; start_s = 1'b0;
    bus.req_valid = 1'b0; bus.req_kind = '0; bus.req_funct3 = '0; bus.req_funct7 = '0;
    bus.req_rd = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_imm = '0; bus.req_last = 1'b0;
    sbus.req_valid = 1'b0; sbus.req_kind = '0; sbus.req_funct3 = '0; sbus.req_funct7 = '0;
    sbus.req_rd = '0; sbus.req_rs1 = '0; sbus.req_rs2 = '0; sbus.req_imm = '0; sbus.req_last = 1'b0;

    repeat (3) @(posedge clk); #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_count", {21'b0, inst_count}, 0);
    check("rst_err", {30'b0, err_code}, 0);
    check("rst_ready", {31'b0, bus.req_ready}, 0);
    check("rst_we", {31'b0, bus.imem_we}, 0);
    check("rst_addr", {22'b0, bus.imem_addr}, 0);
    check("rst_wdata", bus.imem_wdata, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors; start pulses inside the session must be ignored
    start_session();
    do_req(0, 0, 0, 3, 1, 2, 0, 1'b0, 1'b0);
    check("r_add_word", bus.imem_wdata, 32'h002081B3);
    do_req(1, 0, 0, 1, 0, 0, -1, 1'b0, 1'b1);
    check("addi_word", bus.imem_wdata, 32'hFFF00093);
    do_req(3, 2, 0, 0, 1, 2, 8, 1'b0, 1'b1);
    check("sw_word", bus.imem_wdata, 32'h0020A423);
    do_req(4, 0, 0, 0, 1, 2, -4, 1'b0, 1'b0);
    check("beq_word", bus.imem_wdata, 32'hFE208EE3);
    do_req(5, 0, 0, 1, 0, 0, 8, 1'b1, 1'b0);
    check("jal_word", bus.imem_wdata, 32'h008000EF);
    check("jal_count", {21'b0, inst_count}, 1 + 4);

    // Reserved kind first: its error code must survive later range violations
    start_session();
    do_req(7, 3, 5, 7, 9, 11, 0, 1'b0, 1'b0);
    do_req(1, 0, 0, 5, 6, 0, 4096, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rand_req(1'b0);
    do_req(6, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

    // Clean session starting with an out-of-range I immediate
    start_session();
    do_req(1, 0, 0, 1, 2, 0, 4096, 1'b0, 1'b0);
    for (int s = 0; s < 6; s++) begin
      n = int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) rand_req(1'b0);
      rand_req(1'b1);
      start_session();
    end
    do_req(2, 2, 0, 4, 5, 0, -2048, 1'b0, 1'b0);

    // Asynchronous reset while a word is being written
    do_req(0, 7, 32, 1, 2, 3, 0, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_kind = 3'd1; bus.req_imm = 21'd5; bus.req_last = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("pre_reset_we", {31'b0, bus.imem_we}, 1);
    rst_n = 1'b0; #1;
    check("ar_we", {31'b0, bus.imem_we}, 0);
    check("ar_addr", {22'b0, bus.imem_addr}, 0);
    check("ar_wdata", bus.imem_wdata, 0);
    check("ar_busy", {31'b0, busy}, 0);
    check("ar_count", {21'b0, inst_count}, 0);
    check("ar_ready", {31'b0, bus.req_ready}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Tiny memory: ADDR_W=2, BASE_ADDR=1 wraps and overflows after 4 words
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      sbus.req_valid = 1'b1; sbus.req_kind = 3'd0; sbus.req_last = 1'b0;
      sbus.req_rd = 5'(i + 1); sbus.req_rs1 = 5'(i * 3); sbus.req_rs2 = 5'(31 - i);
      sbus.req_funct3 = 3'(i); sbus.req_funct7 = 7'(i * 9);
      while (sbus.req_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      if (sbus.req_ready !== 1'b1) begin check("s_handshake_timeout", 0, 1); break; end
      @(posedge clk); #1;
      sbus.req_valid = 1'b0;
      w = ref_word(0, i, i * 9, i + 1, i * 3, 31 - i, 0);
      check("s_we", {31'b0, sbus.imem_we}, 1);
      check("s_addr", {30'b0, sbus.imem_addr}, 32'((i + 1) % 4));
      check("s_wdata", sbus.imem_wdata, w);
      @(negedge clk);
    end
    sbus.req_valid = 1'b1;
    @(posedge clk); #1;
    check("s_done", {31'b0, done_s}, 1);
    check("s_err", {30'b0, err_code_s}, 2);
    check("s_count", {29'b0, inst_count_s}, 4);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (sbus.imem_we || sbus.req_ready) hits++;
    end
    check("s_no_accept", 32'(hits), 0);
    check("s_busy_end", {31'b0, busy_s}, 0);
    sbus.req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
